// File: rtl/tap_pkg.sv
// tap_pkg: shared definitions for the IEEE 1149.1 TAP controller.
//   - tap_state_e     : 4-bit TAP state type carrying the fixed state codes
//   - TAP_RESET_STATE : state forced by TRST (Test-Logic-Reset)
//   - tap_next        : next-state function (state, TMS) -> state
//   - in_dr_column    : true for Select-DR-Scan .. Update-DR
//   - in_ir_column    : true for Select-IR-Scan .. Update-IR
package tap_pkg;

    typedef enum logic [3:0] {
        StExit2Dr        = 4'h0,
        StExit1Dr        = 4'h1,
        StShiftDr        = 4'h2,
        StPauseDr        = 4'h3,
        StSelectIr       = 4'h4,
        StUpdateDr       = 4'h5,
        StCaptureDr      = 4'h6,
        StSelectDr       = 4'h7,
        StExit2Ir        = 4'h8,
        StExit1Ir        = 4'h9,
        StShiftIr        = 4'hA,
        StPauseIr        = 4'hB,
        StRunIdle        = 4'hC,
        StUpdateIr       = 4'hD,
        StCaptureIr      = 4'hE,
        StTestLogicReset = 4'hF
    } tap_state_e;

    localparam tap_state_e TAP_RESET_STATE = StTestLogicReset;

    function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
        tap_state_e n;
        case (s)
            StTestLogicReset: n = tms ? StTestLogicReset : StRunIdle;
            StRunIdle:        n = tms ? StSelectDr       : StRunIdle;
            StSelectDr:       n = tms ? StSelectIr       : StCaptureDr;
            StSelectIr:       n = tms ? StTestLogicReset : StCaptureIr;
            StCaptureDr:      n = tms ? StExit1Dr        : StShiftDr;
            StShiftDr:        n = tms ? StExit1Dr        : StShiftDr;
            StExit1Dr:        n = tms ? StUpdateDr       : StPauseDr;
            StPauseDr:        n = tms ? StExit2Dr        : StPauseDr;
            StExit2Dr:        n = tms ? StUpdateDr       : StShiftDr;
            StUpdateDr:       n = tms ? StSelectDr       : StRunIdle;
            StCaptureIr:      n = tms ? StExit1Ir        : StShiftIr;
            StShiftIr:        n = tms ? StExit1Ir        : StShiftIr;
            StExit1Ir:        n = tms ? StUpdateIr       : StPauseIr;
            StPauseIr:        n = tms ? StExit2Ir        : StPauseIr;
            StExit2Ir:        n = tms ? StUpdateIr       : StShiftIr;
            StUpdateIr:       n = tms ? StSelectDr       : StRunIdle;
            default:          n = TAP_RESET_STATE;
        endcase
        return n;
    endfunction

    function automatic logic in_dr_column(input tap_state_e s);
        return s inside {StSelectDr, StCaptureDr, StShiftDr, StExit1Dr,
                         StPauseDr, StExit2Dr, StUpdateDr};
    endfunction

    function automatic logic in_ir_column(input tap_state_e s);
        return s inside {StSelectIr, StCaptureIr, StShiftIr, StExit1Ir,
                         StPauseIr, StExit2Ir, StUpdateIr};
    endfunction

endpackage

// File: rtl/tap_controller.sv
// tap_controller: IEEE 1149.1 TAP state machine (16-state Moore FSM on TCK/TMS).
// Every output is a register loaded from a decode of the next state, so each
// output is valid in the same cycle as the state it describes and is glitch-free.
//
// Ports:
//   TCK             in   test clock, rising edge active
//   TRST            in   asynchronous active-high reset to Test-Logic-Reset
//   TMS             in   test mode select
//   ENABLE          out  1 = DR column, 0 = IR column; holds in TLR/RTI
//   SHIFT           out  register clock-enable (Capture-xR, Shift-xR)
//   MODE_SHIFT_LOAD out  0 = parallel load, 1 = serial shift (Shift-xR only)
//   UPDATE          out  high in Update-xR
//   TDO_EN          out  high in Shift-DR / Shift-IR
//   TLR             out  high in Test-Logic-Reset
//   STATE[3:0]      out  registered state code; only when TAP_STATE_OUT_EN is defined
//
// Build option: define TAP_STATE_OUT_EN to expose the STATE port.
module tap_controller
    import tap_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST,
    input  logic       TMS,
    output logic       ENABLE,
    output logic       SHIFT,
    output logic       MODE_SHIFT_LOAD,
    output logic       UPDATE,
    output logic       TDO_EN,
    output logic       TLR
`ifdef TAP_STATE_OUT_EN
    ,
    output logic [3:0] STATE
`endif
);

    tap_state_e state_q;
    tap_state_e state_d;
    logic       enable_d;

    always_comb begin
        state_d = tap_next(state_q, TMS);
    end

    // Column select only changes when entering a column; TLR and RTI keep it.
    always_comb begin
        enable_d = ENABLE;
        if (in_dr_column(state_d)) begin
            enable_d = 1'b1;
        end else if (in_ir_column(state_d)) begin
            enable_d = 1'b0;
        end
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q         <= TAP_RESET_STATE;
            ENABLE          <= 1'b0;
            SHIFT           <= 1'b0;
            MODE_SHIFT_LOAD <= 1'b0;
            UPDATE          <= 1'b0;
            TDO_EN          <= 1'b0;
            TLR             <= 1'b1;
        end else begin
            state_q         <= state_d;
            ENABLE          <= enable_d;
            SHIFT           <= state_d inside {StCaptureDr, StShiftDr, StCaptureIr, StShiftIr};
            MODE_SHIFT_LOAD <= state_d inside {StShiftDr, StShiftIr};
            UPDATE          <= state_d inside {StUpdateDr, StUpdateIr};
            TDO_EN          <= state_d inside {StShiftDr, StShiftIr};
            TLR             <= (state_d == StTestLogicReset);
        end
    end

`ifdef TAP_STATE_OUT_EN
    assign STATE = state_q;
`endif

endmodule
